// File: rtl/i2c_slave_regbank.sv
//==========================================================================
// Module   : i2c_slave_regbank
// Brief    : I2C slave exposing NREGS 8-bit registers on IOout. After a
//            write address, the first byte selects the register pointer and
//            later bytes are written with pointer auto-increment (wrapping).
//            The optional read-back path is built when the macro
//            I2C_SLAVE_READ_EN is defined.
// Revision : 1.0  initial release
//==========================================================================
`default_nettype none

module i2c_slave_regbank #(
    parameter int NREGS = 4,
    parameter int FILT  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               SCL,
    inout  wire                SDA,
    input  logic [6:0]         ADR,
    output logic [8*NREGS-1:0] IOout,
    output logic               busy
);

    localparam int         c_PW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [3:0] c_FILT_M1 = 4'(FILT - 1);
    localparam logic [7:0] c_NREGS   = 8'(NREGS);
    localparam logic [7:0] c_LAST    = 8'(NREGS - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  w_raw, w_filt;
    logic        w_scl, w_sda, r_scl_d, r_sda_d;
    logic        w_scl_rise, w_scl_fall, w_start, w_stop, w_rx;
    logic        r_sda_oe, w_sda_oe_nxt, r_busy, r_byte_done;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift, r_ptr, w_ptr_inc;
    logic [7:0]  r_regs [NREGS];
    logic        w_clr_bits, w_load_ptr, w_write, w_inc_ptr, w_bit_step;
`ifdef I2C_SLAVE_READ_EN
    logic        w_load_tx, w_shift_tx, r_mack;
    logic [7:0]  w_tx_byte;
`endif

    assign w_raw = {SDA, SCL};

    for (genvar gi = 0; gi < 2; gi++) begin : g_filt
        logic       r_meta, r_sync, r_lvl;
        logic [3:0] r_cnt;
        // Synchronise the bus line, then accept a new level only after FILT equal samples
        always_ff @(posedge clk) begin
            if (reset) begin
                r_meta <= 1'b1;
                r_sync <= 1'b1;
                r_lvl  <= 1'b1;
                r_cnt  <= '0;
            end else begin
                r_meta <= w_raw[gi];
                r_sync <= r_meta;
                if (r_sync == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_FILT_M1) begin
                    r_lvl <= r_sync;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
        end
        assign w_filt[gi] = r_lvl;
    end

    assign w_scl      = w_filt[0];
    assign w_sda      = w_filt[1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & ~r_sda_d & w_sda;
    assign w_rx       = (r_state == ADDR) || (r_state == PTR) || (r_state == WDATA);
    assign w_ptr_inc  = (r_ptr == c_LAST) ? 8'd0 : r_ptr + 8'd1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode and datapath strobes; START/STOP override every state
    always_comb begin
        w_state_nxt  = r_state;
        w_sda_oe_nxt = r_sda_oe;
        w_clr_bits   = 1'b0;
        w_load_ptr   = 1'b0;
        w_write      = 1'b0;
        w_inc_ptr    = 1'b0;
        w_bit_step   = w_scl_rise & w_rx;
`ifdef I2C_SLAVE_READ_EN
        w_load_tx    = 1'b0;
        w_shift_tx   = 1'b0;
        w_tx_byte    = r_regs[r_ptr[c_PW-1:0]];
`endif
        if (w_start) begin
            w_state_nxt  = ADDR;
            w_sda_oe_nxt = 1'b0;
            w_clr_bits   = 1'b1;
        end else if (w_stop) begin
            w_state_nxt  = IDLE;
            w_sda_oe_nxt = 1'b0;
        end else begin
            case (r_state)
                ADDR: if (r_byte_done) begin
                    if (r_shift[7:1] == ADR && !r_shift[0]) w_state_nxt = ADDR_ACK;
`ifdef I2C_SLAVE_READ_EN
                    else if (r_shift[7:1] == ADR)           w_state_nxt = ADDR_ACK;
`endif
                    else                                    w_state_nxt = IGNORE;
                end
                PTR: if (r_byte_done) begin
                    // An out-of-range pointer is refused and the old pointer kept
                    if (r_shift < c_NREGS) begin
                        w_load_ptr  = 1'b1;
                        w_state_nxt = PTR_ACK;
                    end else begin
                        w_state_nxt = IGNORE;
                    end
                end
                WDATA: if (r_byte_done) begin
                    w_write     = 1'b1;
                    w_inc_ptr   = 1'b1;
                    w_state_nxt = WDATA_ACK;
                end
                // First SCL fall pulls SDA low, the second ends the ACK slot
                ADDR_ACK, PTR_ACK, WDATA_ACK: if (w_scl_fall) begin
                    if (!r_sda_oe) begin
                        w_sda_oe_nxt = 1'b1;
                    end else begin
                        w_sda_oe_nxt = 1'b0;
                        w_clr_bits   = 1'b1;
                        if (r_state == ADDR_ACK) begin
`ifdef I2C_SLAVE_READ_EN
                            if (r_shift[0]) begin
                                w_state_nxt  = RDATA;
                                w_load_tx    = 1'b1;
                                w_sda_oe_nxt = ~w_tx_byte[7];
                            end else begin
                                w_state_nxt  = PTR;
                            end
`else
                            w_state_nxt = PTR;
`endif
                        end else begin
                            w_state_nxt = WDATA;
                        end
                    end
                end
`ifdef I2C_SLAVE_READ_EN
                RDATA: if (w_scl_fall) begin
                    if (r_bit_cnt == 3'd7) begin
                        w_sda_oe_nxt = 1'b0;
                        w_clr_bits   = 1'b1;
                        w_state_nxt  = RACK;
                    end else begin
                        w_bit_step   = 1'b1;
                        w_shift_tx   = 1'b1;
                        w_sda_oe_nxt = ~r_shift[6];
                    end
                end
                RACK: if (w_scl_fall) begin
                    w_inc_ptr = 1'b1;
                    w_tx_byte = r_regs[w_ptr_inc[c_PW-1:0]];
                    if (!r_mack) begin
                        w_state_nxt  = RDATA;
                        w_load_tx    = 1'b1;
                        w_sda_oe_nxt = ~w_tx_byte[7];
                    end else begin
                        w_state_nxt  = IGNORE;
                    end
                end
`endif
                IDLE, IGNORE: w_state_nxt = r_state;
                default:      w_state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: edge history, shifter, bit counter, pointer, register bank, busy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_d     <= 1'b1;
            r_sda_d     <= 1'b1;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_byte_done <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_ptr       <= '0;
`ifdef I2C_SLAVE_READ_EN
            r_mack      <= 1'b1;
`endif
            for (int k = 0; k < NREGS; k++) r_regs[k] <= 8'hFF;
        end else begin
            r_scl_d     <= w_scl;
            r_sda_d     <= w_sda;
            r_sda_oe    <= w_sda_oe_nxt;
            r_byte_done <= w_scl_rise & w_rx & (r_bit_cnt == 3'd7) & ~w_start & ~w_stop;
            if (w_start)     r_busy <= 1'b1;
            else if (w_stop) r_busy <= 1'b0;
            if (w_clr_bits)      r_bit_cnt <= '0;
            else if (w_bit_step) r_bit_cnt <= r_bit_cnt + 3'd1;
`ifdef I2C_SLAVE_READ_EN
            if (w_scl_rise && r_state == RACK) r_mack <= w_sda;
            if (w_load_tx)                     r_shift <= w_tx_byte;
            else if (w_shift_tx)               r_shift <= {r_shift[6:0], 1'b1};
            else
`endif
            if (w_scl_rise && w_rx)            r_shift <= {r_shift[6:0], w_sda};
            if (w_load_ptr)     r_ptr <= r_shift;
            else if (w_inc_ptr) r_ptr <= w_ptr_inc;
            if (w_write) r_regs[r_ptr[c_PW-1:0]] <= r_shift;
        end
    end

    for (genvar gk = 0; gk < NREGS; gk++) begin : g_out
        assign IOout[8*gk +: 8] = r_regs[gk];
    end

    assign SDA  = r_sda_oe ? 1'b0 : 1'bz;
    assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_regbank.sv
//==========================================================================
// Module   : tb_i2c_slave_regbank
// Brief    : Directed bench for i2c_slave_regbank (ADR=7'h20, NREGS=4).
//            The read sequence is exercised when I2C_SLAVE_READ_EN is set.
// Revision : 1.0  initial release
//==========================================================================
`default_nettype none

module tb_i2c_slave_regbank;

    localparam int NREGS = 4;
    localparam int FILT  = 3;
    localparam int Q     = 8;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              scl   = 1'b1;
    logic              m_low = 1'b0;
    wire               sda;
    logic [8*NREGS-1:0] io;
    logic              busy;
    logic [3:0][7:0]   exp_io = {4{8'hFF}};
    logic              ack;
    logic [7:0]        rd;
    int                n_chk  = 0;
    int                n_pass = 0;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave_regbank #(.NREGS(NREGS), .FILT(FILT)) dut (
        .clk   (clk),
        .reset (reset),
        .SCL   (scl),
        .SDA   (sda),
        .ADR   (7'h20),
        .IOout (io),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_low = 1'b0; tick(Q);
        scl   = 1'b1; tick(Q);
        m_low = 1'b1; tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; tick(Q);
        scl   = 1'b1; tick(Q);
        m_low = 1'b0; tick(2*Q);
    endtask

    task automatic write_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            m_low = ~b[i]; tick(Q);
            scl   = 1'b1;  tick(2*Q);
            scl   = 1'b0;  tick(Q);
        end
    endtask

    task automatic wr(input string tag, input logic [7:0] b, input logic exp_ack);
        write_bits(b, 8);
        m_low = 1'b0; tick(Q);
        scl   = 1'b1; tick(Q);
        ack   = (sda === 1'b0);
        tick(Q);
        scl   = 1'b0; tick(Q);
        check(tag, 32'(ack), 32'(exp_ack));
    endtask

    task automatic rd_byte(input logic send_ack, output logic [7:0] b);
        m_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            tick(Q);
            scl  = 1'b1; tick(Q);
            b[i] = (sda !== 1'b0);
            tick(Q);
            scl  = 1'b0; tick(Q);
        end
        m_low = send_ack; tick(Q);
        scl   = 1'b1;     tick(2*Q);
        scl   = 1'b0;     tick(Q);
        m_low = 1'b0;
    endtask

    initial begin
        tick(4);
        check("rst_io",   io, 32'hFFFF_FFFF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sda",  32'(sda), 32'd1);
        reset = 1'b0;
        tick(2*Q);

        // Single write to register 1
        i2c_start();
        check("busy_on", 32'(busy), 32'd1);
        wr("w1_adr", 8'h40, 1'b1);
        wr("w1_ptr", 8'h01, 1'b1);
        wr("w1_dat", 8'hA5, 1'b1);
        i2c_stop();
        exp_io[1] = 8'hA5;
        check("busy_off", 32'(busy), 32'd0);
        check("w1_io", io, exp_io);

        // Burst write wrapping from register 3 to 0 and 1
        i2c_start();
        wr("w2_adr", 8'h40, 1'b1);
        wr("w2_ptr", 8'h03, 1'b1);
        wr("w2_d0",  8'h11, 1'b1);
        wr("w2_d1",  8'h22, 1'b1);
        wr("w2_d2",  8'h33, 1'b1);
        i2c_stop();
        exp_io[3] = 8'h11; exp_io[0] = 8'h22; exp_io[1] = 8'h33;
        check("w2_io",  io, 32'h11FF_3322);
        check("w2_ptr", 32'(dut.r_ptr), 32'd2);

        // Wrong address is ignored entirely; out-of-range pointer is NACKed
        i2c_start();
        wr("bad_adr", 8'h42, 1'b0);
        wr("bad_ptr", 8'h00, 1'b0);
        wr("bad_dat", 8'h55, 1'b0);
        i2c_stop();
        check("bad_io", io, exp_io);
        i2c_start();
        wr("p7_adr", 8'h40, 1'b1);
        wr("p7_ptr", 8'h07, 1'b0);
        i2c_stop();
        check("p7_io", io, exp_io);

        // Preload registers 1 and 2, then point at 1
        i2c_start();
        wr("pre_adr", 8'h40, 1'b1);
        wr("pre_ptr", 8'h01, 1'b1);
        wr("pre_d1",  8'h3C, 1'b1);
        wr("pre_d2",  8'hC3, 1'b1);
        i2c_stop();
        exp_io[1] = 8'h3C; exp_io[2] = 8'hC3;
        i2c_start();
        wr("pt_adr", 8'h40, 1'b1);
        wr("pt_ptr", 8'h01, 1'b1);
        i2c_stop();
        check("pre_io", io, exp_io);
`ifdef I2C_SLAVE_READ_EN
        i2c_start();
        wr("rd_adr", 8'h41, 1'b1);
        rd_byte(1'b1, rd);
        check("rd_b0", 32'(rd), 32'h3C);
        rd_byte(1'b0, rd);
        check("rd_b1", 32'(rd), 32'hC3);
        i2c_stop();
        check("rd_ptr", 32'(dut.r_ptr), 32'd3);
`else
        i2c_start();
        wr("rd_nack", 8'h41, 1'b0);
        i2c_stop();
        check("rd_io", io, exp_io);
`endif

        // One-clock SDA glitches with SCL high must not look like START/STOP
        m_low = 1'b1; tick(1); m_low = 1'b0; tick(2*Q);
        check("glitch_start", 32'(busy), 32'd0);
        m_low = 1'b1; tick(Q);
        m_low = 1'b0; tick(1); m_low = 1'b1; tick(Q);
        check("glitch_stop", 32'(busy), 32'd1);
        scl = 1'b0; tick(Q);
        wr("g_adr", 8'h40, 1'b1);
        wr("g_ptr", 8'h00, 1'b1);
        wr("g_dat", 8'h77, 1'b1);
        i2c_stop();
        exp_io[0] = 8'h77;
        check("g_io", io, exp_io);

        // Reset while the slave is holding an ACK low
        i2c_start();
        wr("ra_adr", 8'h40, 1'b1);
        wr("ra_ptr", 8'h00, 1'b1);
        write_bits(8'h5A, 8);
        m_low = 1'b0; tick(2);
        check("ra_drive", 32'(sda), 32'd0);
        reset = 1'b1; tick(2);
        check("ra_sda", 32'(sda), 32'd1);
        reset = 1'b0;
        scl = 1'b1; tick(4*Q);

        // Reset at bit 4 of a data byte, then a clean transfer
        i2c_start();
        wr("rb_adr", 8'h40, 1'b1);
        wr("rb_ptr", 8'h02, 1'b1);
        write_bits(8'hF0, 4);
        reset = 1'b1; tick(3);
        exp_io = {4{8'hFF}};
        check("rb_io",   io, exp_io);
        check("rb_sda",  32'(sda), 32'd1);
        check("rb_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        m_low = 1'b0; scl = 1'b1; tick(4*Q);
        i2c_start();
        wr("rc_adr", 8'h40, 1'b1);
        wr("rc_ptr", 8'h00, 1'b1);
        wr("rc_dat", 8'h5A, 1'b1);
        i2c_stop();
        exp_io[0] = 8'h5A;
        check("rc_io", io, exp_io);

        // Repeated START after 4 data bits discards the partial byte
        i2c_start();
        wr("rs_adr", 8'h40, 1'b1);
        wr("rs_ptr", 8'h01, 1'b1);
        write_bits(8'hAB, 4);
        i2c_start();
        check("rs_busy", 32'(busy), 32'd1);
        wr("rs_adr2", 8'h40, 1'b1);
        wr("rs_ptr2", 8'h00, 1'b1);
        wr("rs_dat",  8'h99, 1'b1);
        i2c_stop();
        exp_io[0] = 8'h99;
        check("rs_io",  io, exp_io);
        check("rs_ptr", 32'(dut.r_ptr), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2c_slave_regbank.md
I2C_SLAVE_REGBANK -- requirements
Module: i2c_slave_regbank

Interface
REQ-001 The module SHALL have parameter NREGS, default 4, giving the number of 8-bit output registers (legal 1..16).
REQ-002 The module SHALL have parameter FILT, default 3, giving the number of consecutive equal clk samples needed to accept an SCL/SDA level change (legal 1..15).
REQ-003 The module SHALL have port clk, input, 1 bit: system clock, at least 16x SCL rate; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port SCL, input, 1 bit: I2C clock, asynchronous to clk.
REQ-006 The module SHALL have port SDA, inout, 1 bit: I2C data, open-drain; driven only 1'b0 or high-Z.
REQ-007 The module SHALL have port ADR, input, 7 bits: device address, static during operation.
REQ-008 The module SHALL have port IOout, output, 8*NREGS bits: register bank; register k occupies bits [8k+7:8k].
REQ-009 The module SHALL have port busy, output, 1 bit: high from an accepted START to the next STOP.

Function
REQ-010 SCL and SDA SHALL each pass a 2-flop synchroniser followed by a FILT-sample glitch filter; all decoding uses only the filtered levels.
REQ-011 START SHALL be filtered SDA 1->0 while filtered SCL=1; STOP SHALL be filtered SDA 0->1 while filtered SCL=1.
REQ-012 Bits SHALL be sampled on filtered SCL 0->1, MSB first; the 3-bit bit counter SHALL clear on START and on each ACK slot.
REQ-013 FSM states SHALL be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
REQ-014 START from any state (including repeated START) SHALL enter ADDR; STOP from any state SHALL enter IDLE and release SDA within 1 clk.
REQ-015 After 8 ADDR bits: address==ADR with R/W=0 -> ADDR_ACK then PTR; R/W=1 -> ADDR_ACK then RDATA (see REQ-026); mismatch -> IGNORE, no ACK.
REQ-016 ACK SHALL drive SDA low from the filtered SCL 1->0 ending bit 8 until the filtered SCL 1->0 ending the ACK slot.
REQ-017 First byte after write address SHALL load the 8-bit pointer; pointer < NREGS -> ACK, else NACK and enter IGNORE.
REQ-018 Each WDATA byte SHALL be ACKed and written to register[pointer] on the clk after the 8th bit is sampled.
REQ-019 After each write the pointer SHALL increment, wrapping NREGS-1 -> 0.
REQ-020 A transfer aborted by START/STOP mid-byte SHALL leave registers and pointer unchanged.
REQ-021 In RDATA the slave SHALL present register[pointer] MSB first, changing SDA only after filtered SCL 1->0; a 1 bit is high-Z.
REQ-022 In RACK, master ACK (SDA=0) SHALL increment pointer (with wrap) and continue RDATA; NACK SHALL increment pointer and enter IGNORE.
REQ-023 IGNORE SHALL never drive SDA and SHALL exit only on START or STOP.
REQ-024 busy SHALL be 1 from the clk after START detection until the clk after STOP detection.

Reset
REQ-025 With reset=1 at a clk edge: state=IDLE, pointer=0, bit counter=0, every IOout byte=8'hFF, SDA high-Z, busy=0, filters preset to 1; reset mid-transfer SHALL abort with no further ACK.

Configuration
REQ-026 Macro I2C_SLAVE_READ_EN: defined -> read path of REQ-015/021/022 present; undefined -> address match with R/W=1 SHALL be NACKed, enter IGNORE, and RDATA/RACK logic is absent.

Verification
REQ-027 ADR=7'h20, NREGS=4: START, 0x40, 0x01, 0xA5, STOP -> ACK on all three bytes, IOout[15:8]=0xA5, other bytes 0xFF, busy 1 then 0.
REQ-028 START, 0x40, 0x03, 0x11, 0x22, 0x33, STOP -> reg3=0x11, reg0=0x22, reg1=0x33 (wrap), pointer ends at 2.
REQ-029 START, 0x42 (wrong address), 0x00, 0x55, STOP -> no ACK at any slot, IOout unchanged; START, 0x40, 0x07 -> pointer byte NACKed.
REQ-030 With I2C_SLAVE_READ_EN, pointer=1, reg1=0x3C, reg2=0xC3: START, 0x41, read with ACK then NACK -> SDA bytes 0x3C, 0xC3; without macro: 0x41 NACKed.
REQ-031 1-clk SDA glitch while SCL high (FILT=3) -> no START/STOP detected; reset asserted at bit 4 of a data byte -> IOout all 0xFF, SDA released, next transfer works.
REQ-032 Repeated START after 4 data bits of a write, then 0x40, 0x00, 0x99, STOP -> partial byte discarded, reg0=0x99.
